// File: rtl/commit_trace_buf_pkg.sv
// Shared types for the commit trace buffer: entry layout and event-type codes.
package commit_trace_buf_pkg;

   localparam logic TRC_GRF = 1'b0;
   localparam logic TRC_DM  = 1'b1;
   localparam int   ENTRY_W = 97;

   typedef struct packed {
      logic        kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } trc_entry_t;

   function automatic trc_entry_t make_entry(input logic        kind,
                                             input logic [31:0] pc,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
      trc_entry_t e;
      e.kind = kind;
      e.pc   = pc;
      e.addr = addr;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/commit_trace_buf_if.sv
// Event inputs, trace stream and status of the commit trace buffer.
// Handshake: an entry transfers on a rising edge where trc_valid && trc_ready; trc_* hold while valid && !ready.
interface commit_trace_buf_if #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              grf_we;
   logic [31:0]       grf_pc;
   logic [4:0]        grf_addr;
   logic [31:0]       grf_wd;
   logic              dm_we;
   logic [31:0]       dm_pc;
   logic [31:0]       dm_addr;
   logic [31:0]       dm_wd;
   logic              trc_valid;
   logic              trc_ready;
   logic              trc_type;
   logic [31:0]       trc_pc;
   logic [31:0]       trc_addr;
   logic [31:0]       trc_data;
   logic [CW-1:0]     count;
   logic              overflow;
   logic [CNT_W-1:0]  drop_cnt;

   modport master (
      output grf_we, grf_pc, grf_addr, grf_wd,
      output dm_we, dm_pc, dm_addr, dm_wd,
      output trc_ready,
      input  trc_valid, trc_type, trc_pc, trc_addr, trc_data,
      input  count, overflow, drop_cnt
   );

   modport slave (
      input  grf_we, grf_pc, grf_addr, grf_wd,
      input  dm_we, dm_pc, dm_addr, dm_wd,
      input  trc_ready,
      output trc_valid, trc_type, trc_pc, trc_addr, trc_data,
      output count, overflow, drop_cnt
   );

endinterface

// File: rtl/trace_fifo_2w1r.sv
// Generic register-array FIFO taking up to two writes (we0 slot first) and one show-ahead read per cycle.
// The caller guarantees that accepted writes never exceed the free space including a same-cycle pop.
module trace_fifo_2w1r #(
   parameter int DEPTH = 16,
   parameter int W     = 97
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we0,
   input  logic                     we1,
   input  logic [W-1:0]             din0,
   input  logic [W-1:0]             din1,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr1_addr;

   // we1 lands behind we0 when both fire, otherwise it takes the current write slot.
   always_comb begin
      wr1_addr = wr_ptr_q + AW'(we0);
      wr_ptr_d = wr_ptr_q + AW'(we0) + AW'(we1);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(we0) + CW'(we1) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we0) mem_q[wr_ptr_q] <= din0;
      if (we1) mem_q[wr1_addr] <= din1;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/commit_trace_buf.sv
// Captures GRF write-back and DM store events into a 2-write/1-read FIFO and streams them out;
// never back-pressures the pipeline, counting events that do not fit.
module commit_trace_buf
   import commit_trace_buf_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   commit_trace_buf_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] SP_ONE   = (CW+1)'(1);
   localparam logic [CW:0] SP_TWO   = (CW+1)'(2);
   localparam logic [CW:0] SP_DEPTH = (CW+1)'(DEPTH);

   logic               grf_ev, dm_ev;
   logic               pop;
   logic               acc_grf, acc_dm;
   logic [CW:0]        space;
   logic [CW:0]        dm_need;
   logic [1:0]         n_drop;
   trc_entry_t         grf_e, dm_e, head;
   logic [ENTRY_W-1:0] fifo_dout;
   logic [CW-1:0]      fifo_count;

   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_W:0]     drop_sum;

   // Writes to r0 are architecturally invisible, so they are not events at all.
   always_comb begin
      grf_ev  = bus.grf_we && (bus.grf_addr != 5'd0);
      dm_ev   = bus.dm_we;
      pop     = (fifo_count != '0) && bus.trc_ready;
      space   = SP_DEPTH - {1'b0, fifo_count} + {{CW{1'b0}}, pop};
      dm_need = grf_ev ? SP_TWO : SP_ONE;
      acc_grf = grf_ev && (space >= SP_ONE);
      acc_dm  = dm_ev && (space >= dm_need);
      n_drop  = {1'b0, grf_ev && !acc_grf} + {1'b0, dm_ev && !acc_dm};
      grf_e   = make_entry(TRC_GRF, bus.grf_pc, {27'b0, bus.grf_addr}, bus.grf_wd);
      dm_e    = make_entry(TRC_DM, bus.dm_pc, bus.dm_addr, bus.dm_wd);
   end

   trace_fifo_2w1r #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .we0   (acc_grf),
      .we1   (acc_dm),
      .din0  (grf_e),
      .din1  (dm_e),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   // The extra top bit of drop_sum catches a carry out, which pins the counter at all-ones.
   always_comb begin
      overflow_d = overflow_q || (n_drop != 2'd0);
      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      head          = trc_entry_t'(fifo_dout);
      bus.trc_valid = (fifo_count != '0);
      bus.trc_type  = head.kind;
      bus.trc_pc    = head.pc;
      bus.trc_addr  = head.addr;
      bus.trc_data  = head.data;
      bus.count     = fifo_count;
      bus.overflow  = overflow_q;
      bus.drop_cnt  = drop_cnt_q;
   end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf: vector table for single-entry traffic, sequences for fill/drop/reset.
module tb_commit_trace_buf;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [96:0] exp_q[$];

   typedef struct {
      logic        gwe;
      logic [31:0] gpc;
      logic [4:0]  ga;
      logic [31:0] gwd;
      logic        dwe;
      logic [31:0] dpc;
      logic [31:0] da;
      logic [31:0] dwd;
      logic        rdy;
      int          e_count;
      logic [96:0] e_head;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   commit_trace_buf_if #(.DEPTH(16), .CNT_W(16)) bus ();

   commit_trace_buf #(.DEPTH(16), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [96:0] ent(input logic k, input logic [31:0] pc,
                                       input logic [31:0] addr, input logic [31:0] data);
      return {k, pc, addr, data};
   endfunction

   function automatic logic [96:0] g_ent(input int i);
      return ent(1'b0, 32'h4000 + 32'(8*i), {27'b0, 5'(i % 31 + 1)}, 32'(i));
   endfunction

   function automatic logic [96:0] d_ent(input int i);
      return ent(1'b1, 32'h4004 + 32'(8*i), 32'h100 + 32'(4*i), 32'h1000 + 32'(i));
   endfunction

   task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [96:0] head_now();
      return {bus.trc_type, bus.trc_pc, bus.trc_addr, bus.trc_data};
   endfunction

   task automatic check_status(input string name, input int e_count, input logic e_ovf, input int e_drop);
      check({name, ".valid"}, 97'(bus.trc_valid), 97'(e_count != 0));
      check({name, ".count"}, 97'(bus.count), 97'(e_count));
      check({name, ".overflow"}, 97'(bus.overflow), 97'(e_ovf));
      check({name, ".drop_cnt"}, 97'(bus.drop_cnt), 97'(e_drop));
   endtask

   task automatic drive(input logic gwe, input logic [31:0] gpc, input logic [4:0] ga, input logic [31:0] gwd,
                        input logic dwe, input logic [31:0] dpc, input logic [31:0] da, input logic [31:0] dwd,
                        input logic rdy);
      bus.grf_we = gwe; bus.grf_pc = gpc; bus.grf_addr = ga; bus.grf_wd = gwd;
      bus.dm_we  = dwe; bus.dm_pc  = dpc; bus.dm_addr  = da; bus.dm_wd  = dwd;
      bus.trc_ready = rdy;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, rdy);
   endtask

   // Dual event i: GRF and DM fields follow g_ent(i)/d_ent(i); called at a negedge, returns at the next one.
   task automatic dual_cycle(input int i, input logic rdy);
      drive(1'b1, 32'h4000 + 32'(8*i), 5'(i % 31 + 1), 32'(i),
            1'b1, 32'h4004 + 32'(8*i), 32'h100 + 32'(4*i), 32'h1000 + 32'(i), rdy);
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      idle(1'b0);
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h3000, 5'd8,  32'h12, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, ent(1'b0, 32'h3000, 32'd8, 32'h12)};
      vecs[1] = '{1'b0, 32'h0,    5'd0,  32'h0,  1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 0, '0};
      vecs[2] = '{1'b1, 32'h3000, 5'd0,  32'h12, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 0, '0};
      vecs[3] = '{1'b0, 32'h0,    5'd0,  32'h0,  1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 0, '0};
      vecs[4] = '{1'b1, 32'h3004, 5'd9,  32'h5,  1'b1, 32'h3008, 32'h10, 32'hAB, 1'b0, 2, ent(1'b0, 32'h3004, 32'd9, 32'h5)};
      vecs[5] = '{1'b0, 32'h0,    5'd0,  32'h0,  1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, ent(1'b1, 32'h3008, 32'h10, 32'hAB)};
      vecs[6] = '{1'b0, 32'h0,    5'd0,  32'h0,  1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 0, '0};
      vecs[7] = '{1'b0, 32'h0,    5'd0,  32'h0,  1'b1, 32'h300C, 32'h20, 32'h55, 1'b0, 1, ent(1'b1, 32'h300C, 32'h20, 32'h55)};
      vecs[8] = '{1'b1, 32'h3010, 5'd31, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, ent(1'b0, 32'h3010, 32'd31, 32'hDEADBEEF)};
      vecs[9] = '{1'b0, 32'h0,    5'd0,  32'h0,  1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 0, '0};

      do_reset(5);
      @(negedge clk);
      check_status("reset", 0, 1'b0, 0);

      for (int v = 0; v < 10; v++) begin
         drive(vecs[v].gwe, vecs[v].gpc, vecs[v].ga, vecs[v].gwd,
               vecs[v].dwe, vecs[v].dpc, vecs[v].da, vecs[v].dwd, vecs[v].rdy);
         @(negedge clk);
         check_status($sformatf("vec%0d", v), vecs[v].e_count, 1'b0, 0);
         if (vecs[v].e_count != 0) check($sformatf("vec%0d.head", v), head_now(), vecs[v].e_head);
      end

      // Fill with ready low: 8 dual cycles fill 16 slots, the remaining 12 drop both events.
      for (int i = 0; i < 20; i++) begin
         dual_cycle(i, 1'b0);
         if (i < 8) begin
            exp_q.push_back(g_ent(i));
            exp_q.push_back(d_ent(i));
         end
         if (i == 7) check_status("fill8", 16, 1'b0, 0);
      end
      check_status("fill20", 16, 1'b1, 24);
      check("fill20.head", head_now(), exp_q[0]);

      // Full plus pop: the freed slot takes the GRF event, the DM event drops.
      dual_cycle(20, 1'b1);
      void'(exp_q.pop_front());
      exp_q.push_back(g_ent(20));
      check_status("full_pop", 16, 1'b1, 25);
      check("full_pop.head", head_now(), exp_q[0]);

      for (int k = 0; k < 6; k++) begin
         idle(1'b1);
         @(negedge clk);
         void'(exp_q.pop_front());
      end
      check_status("drain10", 10, 1'b1, 25);

      idle(1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d.head", k), head_now(), exp_q[0]);
         check($sformatf("hold%0d.count", k), 97'(bus.count), 97'(10));
      end

      do_reset(1);
      check_status("mid_reset", 0, 1'b0, 0);

      // Odd occupancy: one GRF then duals reach 15, so the next dual sees space of exactly 1.
      drive(1'b1, 32'h5000, 5'd3, 32'h77, 1'b0, '0, '0, '0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 7; i++) dual_cycle(i, 1'b0);
      check_status("count15", 15, 1'b0, 0);
      dual_cycle(7, 1'b0);
      check_status("space1", 16, 1'b1, 1);
      check("space1.head", head_now(), ent(1'b0, 32'h5000, 32'd3, 32'h77));

      // Saturation: drive the drop counter to all-ones-1, then add two twice.
      do_reset(1);
      for (int i = 0; i < 8; i++) dual_cycle(i, 1'b0);
      check_status("refill", 16, 1'b0, 0);
      for (int i = 0; i < 32767; i++) dual_cycle(i % 64, 1'b0);
      check_status("sat_m1", 16, 1'b1, 32'hFFFE);
      dual_cycle(1, 1'b0);
      check_status("sat_hit", 16, 1'b1, 32'hFFFF);
      dual_cycle(2, 1'b0);
      check_status("sat_hold", 16, 1'b1, 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
